dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the load/store unit's data-memory requests. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. Stores are performed with byte-lane enables; loads are returned already sign- or zero-extended. Each request produces exactly one response, carrying an error flag for misaligned, out-of-range or invalid requests. It sits behind the MEM stage and replaces the single-cycle data array with a latency-tolerant target.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array. Valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1: extra BUSY cycles per access. Legal range 0..7.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  OPERAND_WIDTH  byte address.
- req_wdata  in  OPERAND_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  OPERAND_WIDTH  extended load data. Always 0 for stores and for errors.
- rsp_err  out  1  request was rejected; no memory side effect.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- req_ready = 1 only in IDLE.
- A request is accepted on the edge where req_valid && req_ready. On that edge, req_write, req_size, req_addr and req_wdata are latched and the FSM goes to BUSY with wait_cnt = WAIT_STATES.
- In BUSY:
  - If wait_cnt != 0: decrement wait_cnt, stay in BUSY.
  - If wait_cnt == 0: perform the access on this edge, load the response registers, go to RESP.
- In RESP, rsp_valid = 1. On an edge with rsp_ready = 1, go to IDLE.
- Error conditions (rsp_err = 1, no write, rsp_rdata = 0):
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - Any size with addr >= 4*DEPTH_WORDS.
  - req_size 011, 110 or 111.
  - req_write = 1 with size BU or HU.
- Stores:
  - Word index is addr[AW+1:2].
  - B: byte lane addr[1:0] receives wdata[7:0].
  - H: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - W: all four lanes.
  - Other lanes keep their contents.
- Loads:
  - B/BU select the byte at addr[1:0]; H/HU select the halfword at addr[1]; W returns the whole word.
  - B and H sign-extend; BU and HU zero-extend.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - An accepted but uncommitted store is discarded.
  - Array contents are not cleared by reset.

## Timing
- Accept at the edge ending cycle T. rsp_valid first rises in cycle T+2+WAIT_STATES.
- A store commits at the edge ending cycle T+1+WAIT_STATES. A load issued afterwards sees the new data.
- rsp_valid, rsp_rdata and rsp_err are registered and stay stable while rsp_valid && !rsp_ready.
- Throughput is at most one request per WAIT_STATES+3 cycles. There is one mandatory IDLE cycle after each response handshake.
- req_* inputs are ignored outside IDLE. The requester must hold them stable only until acceptance.
- Reset values: req_ready = 0 during reset and 1 in the first cycle after reset. rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait_cnt = 0.
- Reset asserted in BUSY or RESP: IDLE on the next edge, and the pending response is dropped.

## Structure
- Shared common package holds:
  - OPERAND_WIDTH (32).
  - mem_size_e: SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100, SZ_HU = 3'b101.
  - dmem_state_e: IDLE, BUSY, RESP.
- Sub-module dmem_lane_align (purely combinational):
  - Inputs: size, addr[1:0], wdata, raw word.
  - Outputs: 4-bit byte enable, lane-shifted store word, extended load data, misalign flag.
- The top level holds the FSM, the wait counter, the request latch and the byte-lane array (DEPTH_WORDS x 4 x 8).

## Test plan
- Word store then load, WAIT_STATES = 1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, rsp_err 0, rsp_valid 3 cycles after accept.
- Byte lanes: SW 0x11223344 @0x20; SB 0xAA @0x22.
  - LW @0x20 -> 0x11AA3344.
  - LB @0x22 -> 0xFFFFFFAA.
  - LBU @0x22 -> 0x000000AA.
- Halfword: SH 0x8001 @0x32.
  - LH @0x32 -> 0xFFFF8001.
  - LHU @0x32 -> 0x00008001.
  - LW @0x30 has bits [31:16] = 0x8001.
- Errors:
  - LW @0x41 -> rsp_err 1, rdata 0.
  - SH @0x43 -> rsp_err 1, and a following LW @0x40 is unchanged.
  - LW @0x100 with DEPTH 64 -> rsp_err 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0. Release -> IDLE on the next edge, req_ready 1 the cycle after.
- Reset mid-BUSY: accept SW 0x12345678 @0x50 (WAIT_STATES = 3), assert rst in the first BUSY cycle -> no rsp_valid. A subsequent LW @0x50 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: operand width, access sizes, FSM states.
package dmem_responder_pkg;

    localparam int OPERAND_WIDTH = 32;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: store enables/replicated data, load extract/extend, misalign.
// Purely combinational, no latency, no flow control.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]               size,
    input  logic [1:0]               addr_lo,
    input  logic [OPERAND_WIDTH-1:0] wdata,
    input  logic [OPERAND_WIDTH-1:0] raw_word,
    output logic [3:0]               byte_en,
    output logic [OPERAND_WIDTH-1:0] wdata_lane,
    output logic [OPERAND_WIDTH-1:0] rdata_ext,
    output logic                     misalign
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte   = raw_word[{addr_lo, 3'b000} +: 8];
        sel_half   = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        byte_en    = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        misalign   = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (size == SZ_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
            end
            SZ_H, SZ_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (size == SZ_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
                misalign   = addr_lo[0];
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = raw_word;
                misalign   = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, then one registered response.
// Accept->rsp_valid is WAIT_STATES+2 cycles; req_ready only in IDLE; response held until rsp_ready.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_size,
    input  logic [OPERAND_WIDTH-1:0] req_addr,
    input  logic [OPERAND_WIDTH-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OPERAND_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [OPERAND_WIDTH-1:0] ADDR_LIMIT = OPERAND_WIDTH'(4 * DEPTH_WORDS);

    dmem_state_e              state_q, state_d;
    logic [2:0]               wait_cnt_q, wait_cnt_d;
    logic                     req_write_q, req_write_d;
    logic [2:0]               req_size_q, req_size_d;
    logic [OPERAND_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [OPERAND_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [OPERAND_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;

    logic [3:0][7:0]          mem_q [DEPTH_WORDS];
    logic [AW-1:0]            word_idx;
    logic [OPERAND_WIDTH-1:0] raw_word, wdata_lane, rdata_ext;
    logic [3:0]               byte_en;
    logic                     misalign, size_bad, access_err, mem_we;

    assign word_idx = req_addr_q[AW+1:2];
    assign raw_word = mem_q[word_idx];

    dmem_lane_align u_align (
        .size       (req_size_q),
        .addr_lo    (req_addr_q[1:0]),
        .wdata      (req_wdata_q),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    assign size_bad   = !(req_size_q inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    assign access_err = misalign || size_bad || (req_addr_q >= ADDR_LIMIT)
                      || (req_write_q && (req_size_q == SZ_BU || req_size_q == SZ_HU));

    assign req_ready = rst && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_write_d = req_write_q;
        req_size_d  = req_size_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_write_d = req_write;
                    req_size_d  = req_size;
                    req_addr_d  = req_addr;
                    req_wdata_d = req_wdata;
                    wait_cnt_d  = 3'(WAIT_STATES);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt_q != 3'd0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else begin
                    // reset in this cycle must drop the store, hence rst in the enable
                    mem_we      = rst && req_write_q && !access_err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (req_write_q || access_err) ? '0 : rdata_ext;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 3'd0;
            req_write_q <= 1'b0;
            req_size_q  <= 3'd0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_write_q <= req_write_d;
            req_size_q  <= req_size_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[word_idx][i] <= wdata_lane[8*i +: 8];
            end
        end
    end

endmodule
